rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port (wr/wd/regwr) between two writeback requesters: A = load/memory writeback, B = ALU/execute writeback.
- Also keeps a per-register pending-write scoreboard so decode can stall on registers that still have writes outstanding.
- Sits between the pipeline writeback stages and the RF.
- Drives regwr low whenever no write is presented, so the RF performs its read path on those cycles.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 37 +++
 rtl/rf_wb_arbiter.sv | 99 +++++++++
 tb/tb_rf_wb_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared widths and constants for the register-file writeback arbiter.
package rf_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    // Requester index: REQ_A = load/memory writeback, REQ_B = ALU writeback.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard: set on issue, clear on writeback, set wins.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_valid,
    input  logic [REG_W-1:0]    set_reg,
    input  logic                clr_valid,
    input  logic [REG_W-1:0]    clr_reg,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Register 0 is never tracked, so both masks exclude it.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_valid && set_reg != ZERO_REG) begin
            set_mask[set_reg] = 1'b1;
        end
        if (clr_valid && clr_reg != ZERO_REG) begin
            clr_mask[clr_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the RF write port between load (A) and ALU (B) writeback with
// bounded starvation for B, and tracks outstanding writes per register.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_valid,
    input  logic [REG_W-1:0]    a_reg,
    input  logic [DATA_W-1:0]   a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [REG_W-1:0]    b_reg,
    input  logic [DATA_W-1:0]   b_data,
    output logic                b_ready,
    input  logic                iss_valid,
    input  logic [REG_W-1:0]    iss_reg,
    output logic                regwr,
    output logic [REG_W-1:0]    wr,
    output logic [DATA_W-1:0]   wd,
    output logic [NUM_REGS-1:0] busy
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_WAIT);

    logic [2:0]        wait_cnt;
    logic              xfer;
    req_e              sel;
    logic [REG_W-1:0]  xfer_reg;
    logic [DATA_W-1:0] xfer_data;
    logic              clr_valid;

    // Grants depend only on valids, reset and the wait counter.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        xfer    = 1'b0;
        sel     = REQ_A;
        if (rst_n) begin
            if (b_valid && wait_cnt == MAX_CNT) begin
                b_ready = 1'b1;
                xfer    = 1'b1;
                sel     = REQ_B;
            end else if (a_valid) begin
                a_ready = 1'b1;
                xfer    = 1'b1;
                sel     = REQ_A;
            end else if (b_valid) begin
                b_ready = 1'b1;
                xfer    = 1'b1;
                sel     = REQ_B;
            end
        end
    end

    always_comb begin
        xfer_reg  = (sel == REQ_B) ? b_reg  : a_reg;
        xfer_data = (sel == REQ_B) ? b_data : a_data;
        clr_valid = xfer && (xfer_reg != ZERO_REG);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!b_valid || b_ready) begin
            wait_cnt <= '0;
        end else if (a_ready && wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

    // wr/wd hold their last value on idle cycles; only regwr returns low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwr <= 1'b0;
            wr    <= '0;
            wd    <= '0;
        end else if (xfer) begin
            regwr <= (xfer_reg != ZERO_REG);
            wr    <= xfer_reg;
            wd    <= xfer_data;
        end else begin
            regwr <= 1'b0;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (iss_valid),
        .set_reg   (iss_reg),
        .clr_valid (clr_valid),
        .clr_reg   (xfer_reg),
        .busy      (busy)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench: stimulus queues expected RF writes, a monitor pops and
// compares them whenever regwr is seen high.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        b_ready;
    logic        iss_valid;
    logic [4:0]  iss_reg;
    logic        regwr;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] busy;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rf_wb_arbiter #(.MAX_WAIT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_reg     (a_reg),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_reg     (b_reg),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .iss_valid (iss_valid),
        .iss_reg   (iss_reg),
        .regwr     (regwr),
        .wr        (wr),
        .wd        (wd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with regwr high must match the oldest expected write.
    always @(negedge clk) begin
        if (regwr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got wr=%0d wd=0x%0h expected none", wr, wd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_wr", 32'(wr), 32'(e.r));
                chk("mon_wd", wd, e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0; iss_valid = 1'b0; iss_reg = '0;
        tick(); tick();
        chk("rst_regwr", 32'(regwr), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_busy", busy, 32'd0);
        rst_n = 1'b1;

        // Single write
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h0123;
        #1 chk("single_a_ready", 32'(a_ready), 32'd1);
        chk("single_b_ready", 32'(b_ready), 32'd0);
        expect_wr(5'd5, 32'h0123);
        tick(); a_valid = 1'b0;
        chk("single_regwr", 32'(regwr), 32'd1);
        chk("single_wr", 32'(wr), 32'd5);
        chk("single_wd", wd, 32'h0123);
        tick();
        chk("single_regwr_drop", 32'(regwr), 32'd0);
        chk("single_wr_hold", 32'(wr), 32'd5);
        chk("single_wd_hold", wd, 32'h0123);

        // Reset mid-operation drops the in-flight handshake
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h55; rst_n = 1'b0;
        #1 chk("midrst_a_ready", 32'(a_ready), 32'd0);
        tick();
        chk("midrst_regwr", 32'(regwr), 32'd0);
        chk("midrst_wr", 32'(wr), 32'd0);
        chk("midrst_wd", wd, 32'd0);
        chk("midrst_busy", busy, 32'd0);
        rst_n = 1'b1;
        #1 chk("postrst_a_ready", 32'(a_ready), 32'd1);
        expect_wr(5'd3, 32'h55);
        tick(); a_valid = 1'b0;
        chk("postrst_wr", 32'(wr), 32'd3);

        // Conflict: A wins, B follows when A drops
        a_valid = 1'b1; a_reg = 5'd2; a_data = 32'h22;
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h77;
        #1 chk("conf_a_ready", 32'(a_ready), 32'd1);
        chk("conf_b_ready", 32'(b_ready), 32'd0);
        expect_wr(5'd2, 32'h22);
        tick(); a_valid = 1'b0;
        #1 chk("conf_b_ready2", 32'(b_ready), 32'd1);
        expect_wr(5'd7, 32'h77);
        tick(); b_valid = 1'b0;

        // Starvation: B force-granted on the 4th cycle
        a_valid = 1'b1; b_valid = 1'b1; b_reg = 5'd9; b_data = 32'hAA;
        for (int i = 0; i < 3; i++) begin
            a_reg = 5'(10 + i); a_data = 32'h100 + 32'(i);
            #1 chk("starve_a_ready", 32'(a_ready), 32'd1);
            chk("starve_b_ready", 32'(b_ready), 32'd0);
            expect_wr(5'(10 + i), 32'h100 + 32'(i));
            tick();
        end
        a_reg = 5'd13; a_data = 32'h103;
        #1 chk("force_b_ready", 32'(b_ready), 32'd1);
        chk("force_a_ready", 32'(a_ready), 32'd0);
        expect_wr(5'd9, 32'hAA);
        tick();
        chk("force_wr", 32'(wr), 32'd9);
        chk("force_wd", wd, 32'hAA);
        // Counter cleared by the B grant: A wins again with B still valid
        b_data = 32'hBB;
        #1 chk("cnt_clr_a_ready", 32'(a_ready), 32'd1);
        chk("cnt_clr_b_ready", 32'(b_ready), 32'd0);
        expect_wr(5'd13, 32'h103);
        tick(); a_valid = 1'b0;
        #1 chk("cnt_clr_b_ready2", 32'(b_ready), 32'd1);
        expect_wr(5'd9, 32'hBB);
        tick(); b_valid = 1'b0;

        // Register zero: accepted, discarded, never marked busy
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFF;
        iss_valid = 1'b1; iss_reg = 5'd0;
        #1 chk("zero_b_ready", 32'(b_ready), 32'd1);
        tick(); b_valid = 1'b0; iss_valid = 1'b0;
        chk("zero_regwr", 32'(regwr), 32'd0);
        chk("zero_busy", busy, 32'd0);

        // Scoreboard race: set beats clear on the same register
        iss_valid = 1'b1; iss_reg = 5'd4;
        tick(); iss_valid = 1'b0;
        chk("sb_set4", busy, 32'h10);
        a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h44; iss_valid = 1'b1; iss_reg = 5'd4;
        expect_wr(5'd4, 32'h44);
        tick(); iss_valid = 1'b0; a_data = 32'h45;
        chk("sb_race4", busy, 32'h10);
        expect_wr(5'd4, 32'h45);
        tick(); a_valid = 1'b0;
        chk("sb_clr4", busy, 32'h0);

        // Independent registers: clear of one leaves the other busy
        iss_valid = 1'b1; iss_reg = 5'd6;
        tick(); iss_reg = 5'd8;
        tick(); iss_valid = 1'b0;
        chk("sb_set68", busy, 32'h140);
        b_valid = 1'b1; b_reg = 5'd6; b_data = 32'h66;
        expect_wr(5'd6, 32'h66);
        tick(); b_valid = 1'b0;
        chk("sb_clr6", busy, 32'h100);

        tick(); tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
